// File: rtl/mult_shift_add32.sv
// Sequential 32x32->64 shift-add multiplier, signed or unsigned, fixed 32-iteration latency.
// Operands are latched as magnitudes; the sign is reapplied when the result is loaded.
module mult_shift_add32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [63:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic [63:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] sum;
    logic [63:0] acc_d;
    logic [63:0] result;

    always_comb begin
        mag_a  = (sgn && multiplicand[31]) ? (32'd0 - multiplicand) : multiplicand;
        mag_b  = (sgn && multiplier[31])   ? (32'd0 - multiplier)   : multiplier;
        // 33-bit add keeps the carry, which becomes the new MSB after the shift
        sum    = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
        acc_d  = {sum, acc_q[31:1]};
        result = (neg_q && (acc_d != 64'd0)) ? (64'd0 - acc_d) : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 64'd0;
            neg_q     <= 1'b0;
            product_q <= 64'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= sgn & (multiplicand[31] ^ multiplier[31]);
                        acc_q    <= 64'd0;
                        cnt_q    <= 5'd0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        product_q <= result;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mult_shift_add32.sv
// Bench for mult_shift_add32: directed corner cases, protocol and reset checks, random operands
// compared against a plain-arithmetic reference product.
module tb_mult_shift_add32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [63:0] held;

    mult_shift_add32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sgn          (sgn),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return 64'(ua * ub);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Start an operation; returns just after the accepting edge E0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        multiplicand = a;
        multiplier   = b;
        sgn          = s;
        start        = 1'b1;
        edge1();
        start        = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        chk("accept_done", {63'd0, done}, 64'd0);
        chk("accept_hold", product, held);
        multiplicand = $urandom;
        multiplier   = $urandom;
        sgn          = 1'($urandom);
    endtask

    // Run edges E1..E32; optionally pulse start so it is sampled at edge inject_at.
    task automatic finish_op(input logic [63:0] exp, input int inject_at);
        for (int i = 1; i <= 32; i++) begin
            if (i == inject_at) start = 1'b1;
            edge1();
            start = 1'b0;
            if (i < 32) begin
                if (busy !== 1'b1 || done !== 1'b0 || product !== held)
                    chk("run_state", {busy, done, product[61:0]}, {2'b10, held[61:0]});
                else
                    total++;
            end
        end
        chk("e32_done", {63'd0, done}, 64'd1);
        chk("e32_busy", {63'd0, busy}, 64'd0);
        chk("e32_product", product, exp);
        held = exp;
    endtask

    task automatic idle_after();
        edge1();
        chk("e33_done", {63'd0, done}, 64'd0);
        chk("e33_busy", {63'd0, busy}, 64'd0);
        chk("e33_product", product, held);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
        launch(a, b, s);
        finish_op(ref_mul(a, b, s), 0);
        idle_after();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        held         = 64'd0;
        start        = 1'b0;
        sgn          = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        rst_n        = 1'b0;
        #12;
        chk("reset_product", product, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        start = 1'b1;
        edge1();
        chk("start_in_reset", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        edge1();

        // Directed values against hand-derived constants
        launch(32'h8000_0000, 32'd12354, 1'b0);
        finish_op(64'h0000_1821_0000_0000, 0);
        idle_after();
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op(64'hFFFF_FFFE_0000_0001, 0);
        idle_after();
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_op(64'h0000_0000_0000_0001, 0);
        idle_after();
        launch(32'hFFFF_FFFF, 32'd1, 1'b1);
        finish_op(64'hFFFF_FFFF_FFFF_FFFF, 0);
        idle_after();
        launch(32'h8000_0000, 32'h8000_0000, 1'b1);
        finish_op(64'h4000_0000_0000_0000, 0);
        idle_after();
        launch(32'd0, 32'h8000_0000, 1'b1);
        finish_op(64'd0, 0);
        idle_after();
        op(32'h0000_0005, 32'hFFFF_FFFD, 1'b1);

        // start pulsed at E10 is ignored; start held in DONE chains a second op
        launch(32'd1000, 32'd3000, 1'b0);
        finish_op(64'd3000000, 10);
        launch(32'hFFFF_FFF9, 32'd6, 1'b1);
        finish_op(64'hFFFF_FFFF_FFFF_FFD6, 0);
        idle_after();

        // Reset mid-run aborts without a done pulse
        launch(32'd123, 32'd456, 1'b0);
        for (int i = 0; i < 10; i++) edge1();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        held = 64'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (rst_n && done) chk("no_done_after_rst", {63'd0, done}, 64'd0);
        end
        chk("idle_after_rst", {62'd0, busy, done}, 64'd0);
        launch(32'd7, 32'd6, 1'b0);
        finish_op(64'd42, 0);
        idle_after();

        // Random operands, back-to-back when the coin says so
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (n % 6 == 1) ra = 32'h8000_0000;
            if (n % 6 == 2) rb = 32'd0;
            launch(ra, rb, rs);
            finish_op(ref_mul(ra, rb, rs), (n % 4 == 3) ? int'($urandom_range(1, 31)) : 0);
            if (n % 3 != 0) idle_after();
        end
        idle_after();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_shift_add32.md
MULT_SHIFT_ADD32 -- requirements
Module: mult_shift_add32

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; clock port named clk, reset port named rst_n.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  input  1  rising-edge clock
- rst_n  input  1  async active-low reset
- start  input  1  request new multiply, sampled at posedge clk
- sgn  input  1  1 = operands two's-complement, 0 = unsigned; sampled with start
- multiplicand  input  32  operand A, sampled with start
- multiplier  input  32  operand B, sampled with start
- product  output  64  registered result A*B
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
REQ-003 The block SHALL have no parameters; widths are fixed at 32x32->64.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
REQ-005 In IDLE or DONE, start=1 at a posedge (edge E0) SHALL be accepted: operands and sgn latched, state->RUN, busy=1, iteration counter=0, accumulator cleared, done=0.
REQ-006 In RUN, start SHALL be ignored; operands, sgn and product SHALL not change.
REQ-007 RUN SHALL perform one shift-add iteration per edge, E1..E32: if current LSB of the shifted multiplier magnitude is 1, add the multiplicand magnitude to the upper accumulator half (33-bit add, carry kept), then shift accumulator right by 1.
REQ-008 Latency SHALL be fixed at 32 iterations regardless of operand values (zero operands included); no early termination.
REQ-009 At E32 the block SHALL load product with the final (sign-corrected) 64-bit result, set done=1, clear busy and enter DONE.
REQ-010 DONE SHALL last exactly one cycle; at E33 done=0 and state->IDLE unless start=1, which SHALL be accepted per REQ-005 (back-to-back operation).
REQ-011 product SHALL hold its value from E32 until the next E32 or reset; it SHALL NOT change when a new operation is accepted.
REQ-012 With sgn=0, operands SHALL be treated as unsigned and product = A*B mod 2^64 (exact, no overflow possible).
REQ-013 With sgn=1, magnitudes SHALL be taken at E0 (|0x80000000| = 2^31 as 32-bit unsigned); the unsigned product SHALL be two's-complement negated at E32 iff operand sign bits differ and the result is nonzero.
REQ-014 busy and done SHALL never be 1 simultaneously.
REQ-015 Operand input changes after E0 SHALL have no effect on the running operation.

Reset
REQ-016 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product=64'h0, counter=0 and all internal operand/accumulator registers to 0.
REQ-017 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave per REQ-005.
REQ-018 start SHALL be ignored while rst_n=0.

Verification
REQ-019 Unsigned: sgn=0, A=2^31, B=12354, start one cycle -> busy high E0..E32, done=1 for one cycle after E32, product=64'h0000_1821_0000_0000.
REQ-020 Unsigned max: A=B=32'hFFFF_FFFF, sgn=0 -> product=64'hFFFF_FFFE_0000_0001; same operands with sgn=1 (-1*-1) -> product=64'h0000_0000_0000_0001.
REQ-021 Signed corners: sgn=1, A=32'hFFFF_FFFF, B=1 -> product=64'hFFFF_FFFF_FFFF_FFFF; A=B=32'h8000_0000 -> product=64'h4000_0000_0000_0000; A=0, B=32'h8000_0000 -> product=0 with done still after exactly 32 iterations.
REQ-022 Protocol: start pulsed again at E10 with different operands -> ignored, first result unchanged; start held high during DONE cycle -> second operation accepted at E33, first product held until second E32.
REQ-023 Reset mid-run: rst_n=0 after E10 -> busy, done, product 0 immediately, no done pulse; rst_n=1 then A=7, B=6, sgn=0 -> product=64'd42 after 32 iterations.
